pwm_sched: RTL and testbench

PWM_SCHED -- requirements
Module: pwm_sched

---
 rtl/pwm_sched_pkg.sv | 14 +
 rtl/pwm_sched_frame_timer.sv | 21 ++
 rtl/pwm_sched.sv | 142 ++++++++++++++
 tb/tb_pwm_sched.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pwm_sched_pkg.sv
// pwm_sched_pkg: shared state encoding, widths and table-entry type for the PWM pattern scheduler
package pwm_sched_pkg;
  localparam int CNT_W = 7;
  localparam int DWELL_W = 8;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, STOP} state_e;
  typedef struct packed {
    logic [CNT_W-1:0]   a;
    logic [CNT_W-1:0]   b;
    logic [DWELL_W-1:0] dwell;
  } entry_t;
  function automatic logic [DWELL_W-1:0] dwell_eff(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction
endpackage

// File: rtl/pwm_sched_frame_timer.sv
// frame_timer: frame counter 0..PERIOD_CYCLES-1 with frame-start (wrap) and last-cycle flags
module frame_timer #(
  parameter int PERIOD_CYCLES = 128
) (
  input  logic clkCore,
  input  logic reset,
  input  logic clr_i,
  input  logic run_i,
  output logic wrap_o,
  output logic end_o
);
  localparam int W = $clog2(PERIOD_CYCLES);
  localparam logic [W-1:0] LAST = W'(PERIOD_CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign wrap_o = cnt_q == '0;
  assign end_o  = cnt_q == LAST;
  // clear, hold, or advance the count, folding back to 0 after the last cycle of a frame
  always_comb cnt_d = clr_i ? '0 : !run_i ? cnt_q : end_o ? '0 : cnt_q + 1'b1;
  // count register with synchronous active-low reset
  always_ff @(posedge clkCore) cnt_q <= !reset ? '0 : cnt_d;
endmodule

// File: rtl/pwm_sched.sv
// pwm_sched: steps a PWM generator through a table of {A, B, dwell} entries; PWM_SCHED_LOOP_EN compiles in looping
module pwm_sched
  import pwm_sched_pkg::*;
#(
  parameter int PERIOD_CYCLES = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clkCore,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [CNT_W-1:0]         wr_A,
  input  logic [CNT_W-1:0]         wr_B,
  input  logic [DWELL_W-1:0]       wr_dwell,
  input  logic [$clog2(DEPTH)-1:0] last_idx,
  input  logic                     start,
  input  logic                     abort,
  output logic [CNT_W-1:0]         A_val,
  output logic [CNT_W-1:0]         B_val,
  output logic                     load,
  output logic                     en,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] cur_idx
);
  localparam int AW = $clog2(DEPTH);
`ifdef PWM_SCHED_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  state_e            state_q, state_d;
  entry_t            tbl_q [DEPTH];
  logic [AW-1:0]     idx_q, idx_d, last_q, last_d, nxt_idx;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]  a_q, a_d, b_q, b_d;
  logic              ab_q, ab_d, fin_q, fin_d;
  logic              clr, run, wrap, frame_end, expire, at_last, term;
  frame_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_timer (
    .clkCore(clkCore),
    .reset  (reset),
    .clr_i  (clr),
    .run_i  (run),
    .wrap_o (wrap),
    .end_o  (frame_end)
  );
  assign at_last = idx_q == last_q;
  assign expire  = dwell_q <= DWELL_W'(1);
  assign nxt_idx = at_last ? '0 : idx_q + 1'b1;
  // fin_q marks that the coming wrap ends the sequence: abort seen, or the final entry expired without looping
  assign term    = ab_q | abort | (expire & at_last & !LOOP);
  assign A_val   = a_q;
  assign B_val   = b_q;
  assign cur_idx = idx_q;
  assign busy    = state_q != IDLE;
  // sequencer next state; entry changes are committed on the frame's last cycle so new A/B coincide with the wrap load
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    a_d     = a_q;
    b_d     = b_q;
    ab_d    = ab_q;
    fin_d   = fin_q;
    clr     = 1'b0;
    run     = 1'b0;
    load    = 1'b0;
    en      = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
          last_d  = last_idx;
          dwell_d = dwell_eff(tbl_q[0].dwell);
          a_d     = tbl_q[0].a;
          b_d     = tbl_q[0].b;
          ab_d    = 1'b0;
          fin_d   = 1'b0;
        end
      end
      LOAD: begin
        run     = 1'b1;
        load    = 1'b1;
        en      = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        run  = 1'b1;
        load = wrap;
        en   = !(wrap && fin_q);
        ab_d = ab_q | abort;
        if (wrap && fin_q) state_d = STOP;
        else if (frame_end) begin
          if (term) fin_d = 1'b1;
          else if (expire) begin
            idx_d   = nxt_idx;
            dwell_d = dwell_eff(tbl_q[nxt_idx].dwell);
            a_d     = tbl_q[nxt_idx].a;
            b_d     = tbl_q[nxt_idx].b;
          end else dwell_d = dwell_q - 1'b1;
        end
      end
      STOP: begin
        clr     = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // sequencer registers with synchronous active-low reset
  always_ff @(posedge clkCore) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ab_q    <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ab_q    <= ab_d;
      fin_q   <= fin_d;
    end
  end
  // pattern table: writable only while idle, cleared on reset
  always_ff @(posedge clkCore) begin
    if (!reset) for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    else if (wr_en && !busy) tbl_q[wr_addr] <= {wr_A, wr_B, wr_dwell};
  end
endmodule

// File: tb/tb_pwm_sched.sv
// tb_pwm_sched: randomized and directed checks of pwm_sched against a frame-level trace model
module tb_pwm_sched;
  localparam int P = 8;
  localparam int D = 4;
  localparam int AW = 2;
`ifdef PWM_SCHED_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic clkCore = 1'b0, reset = 1'b0, wr_en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AW-1:0] wr_addr = '0, last_idx = '0;
  logic [6:0] wr_A = '0, wr_B = '0;
  logic [7:0] wr_dwell = '0;
  logic [6:0] A_val, B_val;
  logic load, en, busy, done;
  logic [AW-1:0] cur_idx;
  int n_chk = 0, n_err = 0;
  int m_a [D], m_b [D], m_d [D];
  always #5 clkCore = ~clkCore;
  pwm_sched #(.PERIOD_CYCLES(P), .DEPTH(D)) dut (
    .clkCore (clkCore),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_A    (wr_A),
    .wr_B    (wr_B),
    .wr_dwell(wr_dwell),
    .last_idx(last_idx),
    .start   (start),
    .abort   (abort),
    .A_val   (A_val),
    .B_val   (B_val),
    .load    (load),
    .en      (en),
    .busy    (busy),
    .done    (done),
    .cur_idx (cur_idx)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_out(input string ph, input int c, input int a, input int b, input int ld,
                         input int e, input int bs, input int dn, input int ix);
    chk($sformatf("%s@%0d A_val", ph, c), 32'(A_val), a);
    chk($sformatf("%s@%0d B_val", ph, c), 32'(B_val), b);
    chk($sformatf("%s@%0d load", ph, c), 32'(load), ld);
    chk($sformatf("%s@%0d en", ph, c), 32'(en), e);
    chk($sformatf("%s@%0d busy", ph, c), 32'(busy), bs);
    chk($sformatf("%s@%0d done", ph, c), 32'(done), dn);
    chk($sformatf("%s@%0d cur_idx", ph, c), 32'(cur_idx), ix);
  endtask
  task automatic tick();
    @(posedge clkCore);
    #1;
  endtask
  task automatic wr(input int ad, input int a, input int b, input int d);
    wr_en = 1'b1;
    wr_addr = AW'(ad);
    wr_A = 7'(a);
    wr_B = 7'(b);
    wr_dwell = 8'(d);
    tick();
    wr_en = 1'b0;
    m_a[ad] = a;
    m_b[ad] = b;
    m_d[ad] = d;
  endtask
  // Expected trace: frames are listed entry by entry (dwell 0 counts as 1); frame f starts at cycle 1+f*P
  // relative to the start cycle, and the sequence ends at the first wrap after abort or after the last frame.
  task automatic run_seq(input int last, input int k_in, input int rst_at, input string ph);
    int q[$];
    int base[$];
    int k, t_end, idx, fr;
    k = k_in;
    if (LOOP && k == 0) k = $urandom_range(2, 60);
    for (int e = 0; e <= last; e++)
      for (int j = 0; j < (m_d[e] == 0 ? 1 : m_d[e]); j++) q.push_back(e);
    base = q;
    if (LOOP) while (q.size() < (k - 1) / P + 2) foreach (base[i]) q.push_back(base[i]);
    t_end = LOOP ? 1 << 30 : 1 + q.size() * P;
    if (k > 0 && ((k - 1) / P + 1) * P + 1 < t_end) t_end = ((k - 1) / P + 1) * P + 1;
    idx = 0;
    start = 1'b1;
    last_idx = AW'(last);
    abort = 1'($urandom_range(0, 1));
    for (int c = 1; c <= t_end + 2; c++) begin
      tick();
      start = 1'b0;
      abort = 1'b0;
      wr_en = 1'b0;
      fr = (c - 1) / P;
      if (c <= t_end) begin
        idx = (c == t_end) ? q[fr - 1] : q[fr];
        chk_out(ph, c, m_a[idx], m_b[idx], ((c - 1) % P == 0) ? 1 : 0, (c < t_end) ? 1 : 0, 1, 0, idx);
      end else
        chk_out(ph, c, m_a[idx], m_b[idx], 0, 0, (c == t_end + 1) ? 1 : 0, (c == t_end + 1) ? 1 : 0, idx);
      if (c == rst_at) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk_out({ph, "_rst"}, c + 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < D; i++) begin
          m_a[i] = 0;
          m_b[i] = 0;
          m_d[i] = 0;
        end
        return;
      end
      if (c <= t_end + 1) begin
        abort = (c == k);
        start = ($urandom_range(0, 7) == 0);
        wr_en = ($urandom_range(0, 3) == 0);
        wr_addr = AW'($urandom_range(0, D - 1));
        wr_A = 7'($urandom_range(0, 127));
        wr_B = 7'($urandom_range(0, 127));
        wr_dwell = 8'($urandom_range(0, 255));
        last_idx = AW'($urandom_range(0, D - 1));
      end
    end
  endtask
  initial begin
    for (int i = 0; i < D; i++) begin
      m_a[i] = 0;
      m_b[i] = 0;
      m_d[i] = 0;
    end
    reset = 1'b0;
    tick();
    tick();
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_out("idle_abort", 0, 0, 0, 0, 0, 0, 0, 0);
    wr(0, 10, 20, 2);
    run_seq(0, 0, 0, "single");
    wr(0, 11, 21, 1);
    wr(1, 12, 22, 0);
    wr(2, 13, 23, 3);
    run_seq(2, 0, 0, "three");
    run_seq(2, 12, 0, "abort");
    run_seq(2, 0, 20, "midrun");
    run_seq(0, 0, 0, "after_rst");
    wr(0, 31, 41, 1);
    wr(1, 32, 42, 2);
    run_seq(1, 60, 0, "loop");
    repeat (20) begin
      for (int i = 0; i < D; i++)
        wr(i, $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 3));
      run_seq($urandom_range(0, D - 1), ($urandom_range(0, 1) == 1) ? $urandom_range(2, 100) : 0, 0, "rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
